sobel_frame_sequencer: RTL and testbench

Frame-level sequencer that sits between a pixel source, the Sobel datapath and a gradient consumer. It clears the datapath at frame start and gates the datapath `Enable` per pixel under source valid/ready flow control. Completed gradients are buffered in a small FIFO that drains to a valid/ready consumer. `Finish` is raised only once the datapath reports end of frame and every result has left the block.

---
 rtl/sobel_frame_sequencer.sv | 150 +++++++++++++++
 tb/tb_sobel_frame_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sobel_frame_sequencer
// Purpose  : Frame control for the Sobel datapath: clears it at frame start,
//            gates its advance per pixel and buffers gradients for a consumer.
// Revision : 1.0
// ============================================================================
module sobel_frame_sequencer #(
  parameter int IMG_W      = 16,
  parameter int IMG_H      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       CLK,
  input  logic       Reset_n,
  input  logic       Start,
  input  logic [7:0] Threshold,
  input  logic       Pix_valid,
  input  logic [7:0] Pix_data,
  output logic       Pix_ready,
  output logic       Dp_Reset,
  output logic       Dp_Enable,
  output logic [7:0] Dp_DataIn,
  output logic [7:0] Dp_T,
  input  logic       Dp_isReady,
  input  logic       Dp_isPadding,
  input  logic       Dp_Dop,
  input  logic [7:0] Dp_Gradient,
  input  logic       Dp_isEnd,
  output logic       Out_valid,
  output logic [7:0] Out_data,
  input  logic       Out_ready,
  output logic       Busy,
  output logic       Finish,
  output logic       Overflow,
  output logic       Count_err,
  output logic [2:0] debug_state
);

  localparam int              AW      = $clog2(FIFO_DEPTH);
  localparam int              CW      = AW + 1;
  localparam logic [15:0]     C_NPIX  = 16'(IMG_W * IMG_H);
  localparam logic [CW-1:0]   C_FULL  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]   C_STALL = CW'(FIFO_DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   pix_cnt_q, res_cnt_q;
  logic [7:0]    dp_t_q;
  logic          overflow_q, count_err_q;
  logic          busy_q, dp_reset_q, finish_q;

  logic w_run, w_capture, w_stall, w_room, w_full, w_pop, w_push, w_wr, w_accept;

  assign w_run     = (state_q == S_RUN);
  assign w_capture = w_run | (state_q == S_DRAIN);
  assign w_stall   = (cnt_q >= C_STALL);
  assign w_room    = (pix_cnt_q < C_NPIX);
  assign w_full    = (cnt_q == C_FULL);
  assign w_pop     = (cnt_q != '0) & Out_ready;
  assign w_push    = w_capture & Dp_Dop;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign w_wr      = w_push & (~w_full | w_pop);
  assign w_accept  = Pix_valid & Pix_ready;
  assign cnt_d     = cnt_q + CW'(w_wr) - CW'(w_pop);

  assign Pix_ready   = w_run & Dp_isReady & ~w_stall & w_room;
  assign Dp_Enable   = w_run & ~w_stall & (Dp_isPadding | (Dp_isReady & Pix_valid & w_room));
  assign Dp_DataIn   = Pix_data;
  assign Dp_T        = dp_t_q;
  assign Out_valid   = (cnt_q != '0);
  assign Out_data    = mem_q[rd_ptr_q];
  assign Busy        = busy_q;
  assign Finish      = finish_q;
  assign Dp_Reset    = dp_reset_q;
  assign Overflow    = overflow_q;
  assign Count_err   = count_err_q;
  assign debug_state = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (Start) state_d = S_CLEAR;
      S_CLEAR: state_d = S_RUN;
      S_RUN:   if (Dp_isEnd) state_d = S_DRAIN;
      // Leave once the buffer empties this cycle with nothing arriving.
      S_DRAIN: if ((cnt_d == '0) && !w_push) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      dp_reset_q  <= 1'b0;
      finish_q    <= 1'b0;
      dp_t_q      <= '0;
      overflow_q  <= 1'b0;
      count_err_q <= 1'b0;
      pix_cnt_q   <= '0;
      res_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= (state_d != S_IDLE);
      dp_reset_q <= (state_d == S_CLEAR);
      finish_q   <= (state_d == S_DONE);
      if (state_q == S_IDLE && Start) begin
        dp_t_q      <= Threshold;
        overflow_q  <= 1'b0;
        count_err_q <= 1'b0;
        pix_cnt_q   <= '0;
        res_cnt_q   <= '0;
      end else begin
        if (w_accept) pix_cnt_q <= pix_cnt_q + 16'd1;
        if (w_push && res_cnt_q != 16'hFFFF) res_cnt_q <= res_cnt_q + 16'd1;
        if (w_push && !w_wr) overflow_q <= 1'b1;
        if (state_q == S_DONE && res_cnt_q != C_NPIX) count_err_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (w_wr) begin
        mem_q[wr_ptr_q] <= Dp_Gradient;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (w_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sobel_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sobel_frame_sequencer
// Purpose  : Self-checking bench with a stand-in datapath and a queue-based
//            reference model of the sequencer.
// Revision : 1.0
// ============================================================================
module tb_sobel_frame_sequencer;

  localparam int W     = 4;
  localparam int H     = 4;
  localparam int DEPTH = 4;
  localparam int NPIX  = W * H;

  logic       CLK = 1'b0;
  logic       Reset_n, Start, Pix_valid, Pix_ready, Dp_Reset, Dp_Enable;
  logic [7:0] Threshold, Pix_data, Dp_DataIn, Dp_T, Dp_Gradient, Out_data;
  logic       Dp_isReady, Dp_isPadding, Dp_Dop, Dp_isEnd, Out_valid, Out_ready;
  logic       Busy, Finish, Overflow, Count_err;
  logic [2:0] debug_state;

  sobel_frame_sequencer #(.IMG_W(W), .IMG_H(H), .FIFO_DEPTH(DEPTH)) dut (
    .CLK(CLK), .Reset_n(Reset_n), .Start(Start), .Threshold(Threshold),
    .Pix_valid(Pix_valid), .Pix_data(Pix_data), .Pix_ready(Pix_ready),
    .Dp_Reset(Dp_Reset), .Dp_Enable(Dp_Enable), .Dp_DataIn(Dp_DataIn), .Dp_T(Dp_T),
    .Dp_isReady(Dp_isReady), .Dp_isPadding(Dp_isPadding), .Dp_Dop(Dp_Dop),
    .Dp_Gradient(Dp_Gradient), .Dp_isEnd(Dp_isEnd), .Out_valid(Out_valid),
    .Out_data(Out_data), .Out_ready(Out_ready), .Busy(Busy), .Finish(Finish),
    .Overflow(Overflow), .Count_err(Count_err), .debug_state(debug_state)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] pixel(input int i);
    return 8'(i * 7 + 1);
  endfunction

  // Reference model: phase number, latched values, counters, result queue.
  int         m_ph, m_pix, m_res;
  logic [7:0] m_t;
  logic       m_ovf, m_cerr;
  logic [7:0] m_q[$];

  always @(negedge CLK) begin : p_compare
    logic stall, room, e_pr, e_en, pop, push;
    if (!Reset_n) begin
      m_ph = 0; m_pix = 0; m_res = 0; m_t = 8'h00; m_ovf = 1'b0; m_cerr = 1'b0;
      m_q.delete();
      chk("reset_state", debug_state, 0);
      chk("reset_busy", Busy, 0);
      chk("reset_finish", Finish, 0);
      chk("reset_dp_reset", Dp_Reset, 0);
      chk("reset_pix_ready", Pix_ready, 0);
      chk("reset_dp_enable", Dp_Enable, 0);
      chk("reset_out_valid", Out_valid, 0);
      chk("reset_out_data", Out_data, 0);
      chk("reset_dp_t", Dp_T, 0);
      chk("reset_overflow", Overflow, 0);
      chk("reset_count_err", Count_err, 0);
    end else begin
      stall = (m_q.size() >= DEPTH - 1);
      room  = (m_pix < NPIX);
      e_pr  = (m_ph == 2) && Dp_isReady && !stall && room;
      e_en  = (m_ph == 2) && !stall && (Dp_isPadding || (Dp_isReady && Pix_valid && room));
      chk("debug_state", debug_state, m_ph);
      chk("busy", Busy, m_ph != 0);
      chk("finish", Finish, m_ph == 4);
      chk("dp_reset", Dp_Reset, m_ph == 1);
      chk("pix_ready", Pix_ready, e_pr);
      chk("dp_enable", Dp_Enable, e_en);
      chk("dp_datain", Dp_DataIn, Pix_data);
      chk("dp_t", Dp_T, m_t);
      chk("overflow", Overflow, m_ovf);
      chk("count_err", Count_err, m_cerr);
      chk("out_valid", Out_valid, m_q.size() != 0);
      if (m_q.size() != 0) chk("out_data", Out_data, m_q[0]);

      pop  = (m_q.size() != 0) && Out_ready;
      push = (m_ph == 2 || m_ph == 3) && Dp_Dop;
      if (pop) void'(m_q.pop_front());
      if (push) begin
        if (m_q.size() < DEPTH) m_q.push_back(Dp_Gradient);
        else m_ovf = 1'b1;
        if (m_res < 65535) m_res++;
      end
      if (e_pr && Pix_valid) m_pix++;
      case (m_ph)
        0: if (Start) begin
             m_ph = 1; m_t = Threshold; m_ovf = 1'b0; m_cerr = 1'b0; m_pix = 0; m_res = 0;
           end
        1: m_ph = 2;
        2: if (Dp_isEnd) m_ph = 3;
        3: if (m_q.size() == 0 && !push) m_ph = 4;
        default: begin
          if (m_res != NPIX) m_cerr = 1'b1;
          m_ph = 0;
        end
      endcase
    end
  end

  // Observations gathered at the falling edge by the stimulus side.
  logic       s_acc, s_fin;
  logic [7:0] s_pix;
  int         acc_n, fin_n, dpr_n;
  logic [7:0] got[$];

  task automatic step();
    @(negedge CLK);
    s_acc = Pix_valid && Pix_ready;
    s_pix = Pix_data;
    s_fin = Finish;
    if (Finish) fin_n++;
    if (Dp_Reset) dpr_n++;
    if (Out_valid && Out_ready) got.push_back(Out_data);
    @(posedge CLK);
    #1;
  endtask

  // mode: 0 clean, 1 random flow, 2 backpressure, 3 missing result,
  //       4 forced overflow, 5 reset after 7 pixels
  task automatic run_frame(input logic [7:0] thr, input int mode);
    int it;
    acc_n = 0; fin_n = 0; dpr_n = 0; got.delete();
    Start = 1'b1; Threshold = thr; Pix_data = pixel(0);
    step();
    Start = 1'b0;
    chk("clear_cycle", Dp_Reset, 1);
    it = 0;
    while (fin_n == 0 && it < 600) begin
      Dp_Dop = 1'b0; Dp_isEnd = 1'b0;
      if (s_acc) begin
        acc_n++;
        if (!(mode == 3 && acc_n == 5)) begin
          Dp_Dop = 1'b1;
          Dp_Gradient = s_pix ^ thr;
        end
        if (acc_n == NPIX) Dp_isEnd = 1'b1;
      end
      if (mode == 4 && it == 20 && !s_acc) begin
        Dp_Dop = 1'b1;
        Dp_Gradient = 8'hEE;
      end
      if (mode == 5 && acc_n == 7) begin
        Dp_Dop = 1'b0; Dp_isEnd = 1'b0; Reset_n = 1'b0;
        #1;
        chk("abort_busy", Busy, 0);
        chk("abort_state", debug_state, 0);
        chk("abort_pix_ready", Pix_ready, 0);
        chk("abort_enable", Dp_Enable, 0);
        chk("abort_out_valid", Out_valid, 0);
        chk("abort_dp_t", Dp_T, 0);
        step();
        Reset_n = 1'b1;
        repeat (3) step();
        chk("abort_no_finish", fin_n, 0);
        return;
      end
      Pix_data = pixel(acc_n);
      if (mode == 1) begin
        Pix_valid    = ($urandom_range(3) != 0);
        Dp_isReady   = ($urandom_range(4) != 0);
        Dp_isPadding = !Dp_isReady && ($urandom_range(1) == 1);
        Out_ready    = ($urandom_range(3) != 0);
        Start        = ($urandom_range(7) == 0);
        Threshold    = 8'($urandom);
      end else begin
        Pix_valid    = 1'b1;
        Dp_isReady   = 1'b1;
        Dp_isPadding = 1'b0;
        Out_ready    = !((mode == 2 || mode == 4) && it >= 6 && it < 26);
      end
      if (mode == 1 && it == 1) begin
        Pix_valid = 1'b0; Dp_isReady = 1'b0; Dp_isPadding = 1'b1;
        #1;
        chk("padding_enable", Dp_Enable, 1);
        chk("padding_ready", Pix_ready, 0);
      end
      step();
      it++;
    end
    Start = 1'b0; Dp_Dop = 1'b0; Dp_isEnd = 1'b0; Pix_valid = 1'b0;
    Dp_isPadding = 1'b0; Out_ready = 1'b1;
    chk("frame_finished", fin_n, 1);
    step();
    chk("dp_reset_cycles", dpr_n, 1);
    chk("pixels_accepted", acc_n, NPIX);
    chk("results_out", got.size(), (mode == 3) ? NPIX - 1 : NPIX);
    chk("dp_t_latched", Dp_T, thr);
    chk("overflow_flag", Overflow, mode == 4);
    chk("count_err_flag", Count_err, (mode == 3 || mode == 4));
    chk("busy_after", Busy, 0);
    if (mode != 3)
      for (int i = 0; i < got.size() && i < NPIX; i++)
        chk("result_order", got[i], pixel(i) ^ thr);
  endtask

  initial begin
    Reset_n = 1'b0; Start = 1'b0; Threshold = 8'h00; Pix_valid = 1'b0; Pix_data = 8'h00;
    Dp_isReady = 1'b0; Dp_isPadding = 1'b0; Dp_Dop = 1'b0; Dp_Gradient = 8'h00;
    Dp_isEnd = 1'b0; Out_ready = 1'b1;
    s_acc = 1'b0; s_fin = 1'b0; s_pix = 8'h00;
    repeat (3) @(posedge CLK);
    #1;
    chk("init_busy", Busy, 0);
    chk("init_dp_t", Dp_T, 0);
    Reset_n = 1'b1;
    step();

    run_frame(8'h40, 0);
    chk("first_result", got[0], 8'h41);
    chk("last_result", got[NPIX-1], 8'h2A);
    run_frame(8'h40, 2);
    run_frame(8'h9C, 1);
    run_frame(8'h12, 1);
    run_frame(8'h77, 1);
    run_frame(8'h40, 3);
    run_frame(8'h40, 4);
    run_frame(8'h40, 5);
    run_frame(8'h40, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
